// File: rtl/ucq_merge_if.sv
// Producer/consumer bundle for the unit-clause queue merger.
// master = engines + consumer side, slave = ucq_merge.
interface ucq_merge_if #(
  parameter int NUM_CH = 4,
  parameter int LIT_W  = 16,
  parameter int DEPTH  = 16
);
  localparam int CW = $clog2(DEPTH + 1);

  logic [NUM_CH-1:0]       in_valid;
  logic [NUM_CH*LIT_W-1:0] in_lit;
  logic [NUM_CH-1:0]       in_full;
  logic                    out_pop;
  logic [LIT_W-1:0]        out_lit;
  logic                    out_empty;
  logic [CW-1:0]           count;
  logic                    flush;
  logic                    conflict;
  logic                    conflict_clr;

  modport master (
    output in_valid, in_lit, out_pop, flush, conflict_clr,
    input  in_full, out_lit, out_empty, count, conflict
  );

  modport slave (
    input  in_valid, in_lit, out_pop, flush, conflict_clr,
    output in_full, out_lit, out_empty, count, conflict
  );
endinterface

// File: rtl/ucq_merge.sv
// Merges BCP implications from NUM_CH engines into one FIFO with
// conflict detection; define UCQ_MERGE_DEDUP_EN to drop duplicates.
module ucq_merge #(
  parameter int NUM_CH = 4,
  parameter int LIT_W  = 16,
  parameter int DEPTH  = 16
) (
  input  logic        clk,
  input  logic        rst_n,
  ucq_merge_if.slave  s_if
);
  localparam int AW  = $clog2(DEPTH);
  localparam int CW  = $clog2(DEPTH + 1);
  localparam int CHW = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

  typedef logic [LIT_W-1:0] lit_t;

  lit_t              mem_q [DEPTH];
  logic [AW-1:0]     rd_q, rd_d;
  logic [AW-1:0]     wr_q, wr_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic [NUM_CH-1:0] hv_q, hv_d;
  lit_t              hl_q [NUM_CH];
  lit_t              hl_d [NUM_CH];
  logic [CHW-1:0]    rr_q, rr_d;
  logic              conf_q, conf_d;

  logic              pop_ok;
  logic              gnt_v;
  logic              gnt;
  logic              push;
  logic              clash;
  logic [CHW-1:0]    gnt_idx;
  logic [CHW:0]      c;
  logic [AW-1:0]     off;
  lit_t              gnt_lit;
`ifdef UCQ_MERGE_DEDUP_EN
  logic              dup;
`endif

  function automatic logic opp(lit_t a, lit_t b);
    return (a[LIT_W-1:1] == b[LIT_W-1:1]) && (a[0] != b[0]);
  endfunction

  always_comb begin
    pop_ok  = s_if.out_pop && (cnt_q != '0);
    gnt_v   = 1'b0;
    gnt_idx = '0;
    c       = '0;
    // round-robin search starting at the channel after the last grant
    for (int i = 0; i < NUM_CH; i++) begin
      c = {1'b0, rr_q} + (CHW+1)'(i);
      if (c >= (CHW+1)'(NUM_CH))
        c = c - (CHW+1)'(NUM_CH);
      if (!gnt_v && hv_q[c[CHW-1:0]]) begin
        gnt_v   = 1'b1;
        gnt_idx = c[CHW-1:0];
      end
    end
    gnt     = gnt_v && ((cnt_q != CW'(DEPTH)) || pop_ok);
    gnt_lit = hl_q[gnt_idx];

    clash = 1'b0;
    off   = '0;
`ifdef UCQ_MERGE_DEDUP_EN
    dup   = 1'b0;
`endif
    for (int i = 0; i < DEPTH; i++) begin
      off = AW'(i) - rd_q;
      if (CW'(off) < cnt_q) begin
        if (opp(mem_q[i], gnt_lit))
          clash = 1'b1;
`ifdef UCQ_MERGE_DEDUP_EN
        if (mem_q[i] == gnt_lit)
          dup = 1'b1;
`endif
      end
    end
    for (int k = 0; k < NUM_CH; k++) begin
      if (hv_q[k] && (CHW'(k) != gnt_idx) && opp(hl_q[k], gnt_lit))
        clash = 1'b1;
    end

`ifdef UCQ_MERGE_DEDUP_EN
    push = gnt && !dup;
`else
    push = gnt;
`endif

    rd_d   = rd_q + AW'(pop_ok);
    wr_d   = wr_q + AW'(push);
    cnt_d  = cnt_q + CW'(push) - CW'(pop_ok);
    rr_d   = rr_q;
    if (gnt)
      rr_d = (gnt_idx == CHW'(NUM_CH - 1)) ? '0 : gnt_idx + 1'b1;
    conf_d = (gnt && clash) || (conf_q && !s_if.conflict_clr);

    hv_d = hv_q;
    hl_d = hl_q;
    if (gnt)
      hv_d[gnt_idx] = 1'b0;
    // a register freed this edge still looks full, so no same-edge refill
    for (int k = 0; k < NUM_CH; k++) begin
      if (s_if.in_valid[k] && !hv_q[k]) begin
        hv_d[k] = 1'b1;
        hl_d[k] = s_if.in_lit[k*LIT_W +: LIT_W];
      end
    end

    if (s_if.flush) begin
      push   = 1'b0;
      rd_d   = '0;
      wr_d   = '0;
      cnt_d  = '0;
      rr_d   = '0;
      conf_d = 1'b0;
      hv_d   = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rd_q   <= '0;
      wr_q   <= '0;
      cnt_q  <= '0;
      hv_q   <= '0;
      rr_q   <= '0;
      conf_q <= 1'b0;
    end else begin
      rd_q   <= rd_d;
      wr_q   <= wr_d;
      cnt_q  <= cnt_d;
      hv_q   <= hv_d;
      rr_q   <= rr_d;
      conf_q <= conf_d;
    end
  end

  always_ff @(posedge clk) begin
    hl_q <= hl_d;
    if (push && rst_n)
      mem_q[wr_q] <= gnt_lit;
  end

  assign s_if.in_full   = hv_q;
  assign s_if.out_lit   = mem_q[rd_q];
  assign s_if.out_empty = (cnt_q == '0);
  assign s_if.count     = cnt_q;
  assign s_if.conflict  = conf_q;
endmodule

// File: tb/tb_ucq_merge.sv
// Bench for ucq_merge: directed scenarios plus random traffic
// against a queue-based reference model.
module tb_ucq_merge;
  localparam int NUM_CH = 4;
  localparam int LIT_W  = 16;
  localparam int DEPTH  = 16;
`ifdef UCQ_MERGE_DEDUP_EN
  localparam bit DEDUP = 1'b1;
`else
  localparam bit DEDUP = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst_n;

  ucq_merge_if #(.NUM_CH(NUM_CH), .LIT_W(LIT_W), .DEPTH(DEPTH)) bus ();

  ucq_merge #(.NUM_CH(NUM_CH), .LIT_W(LIT_W), .DEPTH(DEPTH)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .s_if  (bus)
  );

  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  task automatic check(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // reference model: queue FIFO, per-channel holding slots, rr pointer
  logic [LIT_W-1:0] mq [$];
  bit [NUM_CH-1:0]  mhv;
  logic [LIT_W-1:0] mhl [NUM_CH];
  int               mrr;
  bit               mconf;
  bit               mvalid = 1'b0;
  bit               m_pop, m_g, m_clash, m_dup;
  int               m_c;
  logic [LIT_W-1:0] m_lit;
  bit [NUM_CH-1:0]  m_hv_old;

  always @(posedge clk) begin
    if (!rst_n || bus.flush) begin
      mq.delete();
      mhv   = '0;
      mrr   = 0;
      mconf = 1'b0;
    end else begin
      m_pop = bus.out_pop && (mq.size() > 0);
      m_g   = 1'b0;
      m_c   = 0;
      for (int i = 0; i < NUM_CH; i++)
        if (!m_g && mhv[(mrr + i) % NUM_CH]) begin
          m_g = 1'b1;
          m_c = (mrr + i) % NUM_CH;
        end
      if (m_g && mq.size() >= DEPTH && !m_pop)
        m_g = 1'b0;
      m_hv_old = mhv;
      m_clash  = 1'b0;
      m_dup    = 1'b0;
      m_lit    = '0;
      if (m_g) begin
        m_lit = mhl[m_c];
        foreach (mq[j]) begin
          if (mq[j] == m_lit) m_dup = 1'b1;
          if ((mq[j] >> 1) == (m_lit >> 1) && mq[j][0] != m_lit[0])
            m_clash = 1'b1;
        end
        for (int k = 0; k < NUM_CH; k++)
          if (k != m_c && mhv[k] && (mhl[k] >> 1) == (m_lit >> 1)
              && mhl[k][0] != m_lit[0])
            m_clash = 1'b1;
      end
      if (m_pop) void'(mq.pop_front());
      if (m_g) begin
        if (!(DEDUP && m_dup)) mq.push_back(m_lit);
        mhv[m_c] = 1'b0;
        mrr = (m_c + 1) % NUM_CH;
      end
      if (m_clash) mconf = 1'b1;
      else if (bus.conflict_clr) mconf = 1'b0;
      for (int k = 0; k < NUM_CH; k++)
        if (bus.in_valid[k] && !m_hv_old[k]) begin
          mhv[k] = 1'b1;
          mhl[k] = bus.in_lit[k*LIT_W +: LIT_W];
        end
    end
    mvalid = 1'b1;
  end

  always @(negedge clk) begin
    if (mvalid) begin
      check("m_count", 32'(bus.count), mq.size());
      check("m_empty", 32'(bus.out_empty), 32'(mq.size() == 0));
      check("m_in_full", 32'(bus.in_full), 32'(mhv));
      check("m_conflict", 32'(bus.conflict), 32'(mconf));
      if (mq.size() > 0)
        check("m_out_lit", 32'(bus.out_lit), 32'(mq[0]));
    end
  end

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic idle();
    bus.in_valid     = '0;
    bus.out_pop      = 1'b0;
    bus.flush        = 1'b0;
    bus.conflict_clr = 1'b0;
  endtask

  task automatic load(int ch, logic [LIT_W-1:0] l);
    bus.in_valid[ch] = 1'b1;
    bus.in_lit[ch*LIT_W +: LIT_W] = l;
  endtask

  task automatic push1(int ch, logic [LIT_W-1:0] l);
    load(ch, l);
    tick();
    bus.in_valid[ch] = 1'b0;
    tick();
  endtask

  task automatic do_flush();
    bus.flush = 1'b1;
    tick();
    bus.flush = 1'b0;
  endtask

  logic [NUM_CH-1:0] exp_full;

  initial begin
    idle();
    bus.in_lit = '0;
    rst_n = 1'b0;
    repeat (2) tick();
    rst_n = 1'b1;
    check("rst_count", 32'(bus.count), 0);
    check("rst_empty", 32'(bus.out_empty), 1);
    check("rst_in_full", 32'(bus.in_full), 0);
    check("rst_conflict", 32'(bus.conflict), 0);

    // two-edge latency, then reset discards the resident entry
    load(0, 16'h0006);
    tick();
    bus.in_valid = '0;
    check("lat1_empty", 32'(bus.out_empty), 1);
    check("lat1_full", 32'(bus.in_full[0]), 1);
    tick();
    check("lat2_empty", 32'(bus.out_empty), 0);
    check("lat2_lit", 32'(bus.out_lit), 32'h6);
    check("lat2_count", 32'(bus.count), 1);
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    check("midrst_count", 32'(bus.count), 0);
    check("midrst_empty", 32'(bus.out_empty), 1);

    // all channels at once: round-robin order from channel 0
    for (int k = 0; k < NUM_CH; k++) load(k, 16'((k + 1) << 4));
    tick();
    bus.in_valid = '0;
    check("rr_full0", 32'(bus.in_full), 32'hF);
    for (int k = 0; k < NUM_CH; k++) begin
      tick();
      exp_full = 4'hF << (k + 1);
      check("rr_full", 32'(bus.in_full), 32'(exp_full));
      check("rr_count", 32'(bus.count), k + 1);
    end
    for (int k = 0; k < NUM_CH; k++) begin
      check("rr_order", 32'(bus.out_lit), (k + 1) << 4);
      bus.out_pop = 1'b1;
      tick();
    end
    bus.out_pop = 1'b0;
    check("rr_drained", 32'(bus.out_empty), 1);

    // full FIFO: pop and pending grant in the same cycle
    for (int i = 0; i < DEPTH; i++) push1(0, 16'((i + 32) << 1));
    check("fill_count", 32'(bus.count), DEPTH);
    load(1, 16'h0100);
    tick();
    bus.in_valid = '0;
    tick();
    check("blk_full", 32'(bus.in_full[1]), 1);
    check("blk_count", 32'(bus.count), DEPTH);
    bus.out_pop = 1'b1;
    tick();
    bus.out_pop = 1'b0;
    check("popgnt_count", 32'(bus.count), DEPTH);
    check("popgnt_full", 32'(bus.in_full[1]), 0);
    check("popgnt_head", 32'(bus.out_lit), 32'h42);
    do_flush();
    check("fl1_count", 32'(bus.count), 0);

    // complementary literals
    push1(0, 16'h000A);
    load(0, 16'h000B);
    tick();
    bus.in_valid = '0;
    check("conf_pre", 32'(bus.conflict), 0);
    tick();
    check("conf_set", 32'(bus.conflict), 1);
    bus.conflict_clr = 1'b1;
    tick();
    bus.conflict_clr = 1'b0;
    check("conf_clr", 32'(bus.conflict), 0);
    do_flush();
    push1(0, 16'h000A);
    load(0, 16'h000B);
    tick();
    bus.in_valid = '0;
    bus.conflict_clr = 1'b1;
    tick();
    bus.conflict_clr = 1'b0;
    check("conf_setclr", 32'(bus.conflict), 1);
    do_flush();

    // duplicate literal
    push1(0, 16'h000A);
    push1(0, 16'h000A);
    check("dup_count", 32'(bus.count), DEDUP ? 1 : 2);
    do_flush();

    // flush with resident entries, holding registers and conflict
    push1(0, 16'h000A);
    push1(0, 16'h000B);
    push1(0, 16'h0020);
    push1(0, 16'h0022);
    push1(0, 16'h0024);
    check("pf_count", 32'(bus.count), 5);
    check("pf_conf", 32'(bus.conflict), 1);
    load(1, 16'h0030);
    load(2, 16'h0032);
    tick();
    bus.in_valid = '0;
    check("pf_hold", 32'(bus.in_full), 32'h6);
    bus.flush = 1'b1;
    load(3, 16'h0040);
    tick();
    idle();
    check("fl_count", 32'(bus.count), 0);
    check("fl_empty", 32'(bus.out_empty), 1);
    check("fl_in_full", 32'(bus.in_full), 0);
    check("fl_conflict", 32'(bus.conflict), 0);

    // random traffic, model-checked every cycle
    for (int n = 0; n < 4000; n++) begin
      bus.in_valid = NUM_CH'($urandom);
      for (int k = 0; k < NUM_CH; k++)
        bus.in_lit[k*LIT_W +: LIT_W] = 16'($urandom_range(0, 11));
      bus.out_pop = ($urandom_range(0, 3) < ((n < 2000) ? 1 : 3));
      bus.flush = ($urandom_range(0, 63) == 0);
      bus.conflict_clr = ($urandom_range(0, 15) == 0);
      rst_n = ($urandom_range(0, 499) != 0);
      tick();
    end
    idle();
    rst_n = 1'b1;
    tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
